// File: rtl/fir_out_quantizer_if.sv
// Stream and status bundle between the FIR output quantizer and its neighbours.
// slave = quantizer side, master = producer/consumer side.
interface fir_out_quantizer_if #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
);
    logic                         in_valid;
    logic signed [IN_W-1:0]       in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_W-1:0]      out_data;
    logic [$clog2(DEPTH):0]       fifo_level;
    logic                         overflow;
    logic                         ovf_clr;

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output out_valid, out_data, fifo_level, overflow
    );

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  out_valid, out_data, fifo_level, overflow
    );
endinterface

// File: rtl/fir_out_quantizer.sv
// Round/scale/saturate the FIR result, then buffer in a DEPTH-entry show-ahead FIFO; 2-cycle latency.
// Input never stalls: a push into a full FIFO is dropped and flagged; FIRQ_SATCNT_EN adds sat_count.
module fir_out_quantizer #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_out_quantizer_if.slave    bus
`ifdef FIRQ_SATCNT_EN
    ,
    output logic [15:0]           sat_count
`endif
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic signed [IN_W:0] RND  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [AW-1:0]        PTR_ONE  = 1;
    localparam logic [LVL_W-1:0]     LVL_ONE  = 1;
    localparam logic [LVL_W-1:0]     FULL_LVL = LVL_W'(DEPTH);

    // Stage 1: one extra bit so the rounding add cannot wrap.
    logic signed [IN_W:0] in_ext;
    logic signed [IN_W:0] rnd_sum;
    logic signed [IN_W:0] r_d;
    logic signed [IN_W:0] r_q;
    logic                 s1_v_q;

    assign in_ext  = {bus.in_data[IN_W-1], bus.in_data};
    assign rnd_sum = in_ext + RND;
    assign r_d     = rnd_sum >>> SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= bus.in_valid;
            if (bus.in_valid) r_q <= r_d;
        end
    end

    // Stage 2: clamp into the OUT_W range.
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        wr_dat;

    always_comb begin
        sat_hi = (r_q > MAXV);
        sat_lo = (r_q < MINV);
        wr_dat = r_q[OUT_W-1:0];
        if (sat_hi)      wr_dat = MAXV[OUT_W-1:0];
        else if (sat_lo) wr_dat = MINV[OUT_W-1:0];
    end

    // FIFO
    logic [OUT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, full, do_wr, drop;

    assign push  = s1_v_q;
    assign pop   = bus.out_valid & bus.out_ready;
    assign full  = (level_q == FULL_LVL);
    assign do_wr = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_wr && !pop)      level_d = level_q + LVL_ONE;
        else if (!do_wr && pop) level_d = level_q - LVL_ONE;
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (drop)             ovf_d = 1'b1;
        else if (bus.ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;

`ifdef FIRQ_SATCNT_EN
    logic        sat;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    assign sat = sat_hi | sat_lo;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (push && sat && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_cnt_q <= '0;
        else      sat_cnt_q <= sat_cnt_d;
    end

    assign sat_count = sat_cnt_q;
`endif
endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: directed corner cases plus random traffic against a queue-based model.
module tb_fir_out_quantizer;
    localparam int IN_W  = 38;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 8;
    localparam longint HI = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint LO = -(longint'(1) << (OUT_W - 1));

    logic clk;
    logic rst;

    fir_out_quantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) intf ();

`ifdef FIRQ_SATCNT_EN
    logic [15:0] sat_count;
`endif

    fir_out_quantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
`ifdef FIRQ_SATCNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a queue of pending samples plus the one-deep input pipeline.
    longint q[$];
    bit     m_s1_v;
    longint m_s1_val;
    bit     m_s1_sat;
    bit     m_ovf;
    int     m_sat;

    function automatic longint quant(input longint x, output bit s);
        longint r;
        r = (x + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        if (r > HI) begin r = HI; s = 1'b1; end
        else if (r < LO) begin r = LO; s = 1'b1; end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_s1_v = 0; m_s1_val = 0; m_s1_sat = 0; m_ovf = 0; m_sat = 0;
    endtask

    task automatic check_outputs();
        chk("vld", longint'(intf.out_valid), longint'(q.size() != 0));
        chk("lvl", longint'(intf.fifo_level), longint'(q.size()));
        chk("dat", longint'(intf.out_data), (q.size() != 0) ? q[0] : 0);
        chk("ovf", longint'(intf.overflow), longint'(m_ovf));
`ifdef FIRQ_SATCNT_EN
        chk("satc", longint'(sat_count), longint'(m_sat));
`endif
    endtask

    // One clock: apply inputs, advance model on the edge, compare on the falling edge.
    task automatic cyc(input bit v, input longint d, input bit rdy, input bit clr);
        bit  s;
        bit  pop;
        bit  full;
        bit  drop;
        intf.in_valid  = v;
        intf.in_data   = d[IN_W-1:0];
        intf.out_ready = rdy;
        intf.ovf_clr   = clr;
        @(posedge clk);
        pop  = rdy && (q.size() != 0);
        full = (q.size() == DEPTH);
        drop = m_s1_v && full && !pop;
        if (m_s1_v && m_s1_sat && m_sat < 65535) m_sat++;
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (m_s1_v && !drop) q.push_back(m_s1_val);
        m_s1_v   = v;
        m_s1_val = quant(d, s);
        m_s1_sat = v && s;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic longint rnd_in();
        longint d;
        case ($urandom_range(0, 3))
            0:       d = $signed({$urandom(), $urandom()}) >>> (64 - IN_W);
            1:       d = longint'($urandom_range(0, 65535)) - 32768;
            default: d = ($signed({$urandom(), $urandom()}) >>> (64 - IN_W)) >>> 6;
        endcase
        return d;
    endfunction

    initial begin
        rst = 1'b0;
        intf.in_valid = 0; intf.in_data = '0; intf.out_ready = 0; intf.ovf_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_vld", longint'(intf.out_valid), 0);
        chk("rst_dat", longint'(intf.out_data), 0);
        chk("rst_lvl", longint'(intf.fifo_level), 0);
        chk("rst_ovf", longint'(intf.overflow), 0);
`ifdef FIRQ_SATCNT_EN
        chk("rst_satc", longint'(sat_count), 0);
`endif
        rst = 1'b1;
        cyc(0, 0, 1, 0);

        // Latency and rounding corners
        cyc(1, 32768, 1, 0);
        chk("lat_n1", longint'(intf.out_valid), 0);
        cyc(0, 0, 1, 0);
        chk("lat_n2", longint'(intf.out_valid), 1);
        chk("rnd_32768", longint'(intf.out_data), 1);
        cyc(1, 16384, 1, 0);  cyc(0, 0, 1, 0);
        chk("rnd_p05", longint'(intf.out_data), 1);
        cyc(1, -16384, 1, 0); cyc(0, 0, 1, 0);
        chk("rnd_m05", longint'(intf.out_data), 0);
        chk("rnd_m05_vld", longint'(intf.out_valid), 1);
        cyc(1, -49152, 1, 0); cyc(0, 0, 1, 0);
        chk("rnd_m15", longint'(intf.out_data), -1);
        cyc(1, (longint'(1) << 37) - 1, 1, 0); cyc(0, 0, 1, 0);
        chk("sat_hi", longint'(intf.out_data), 32767);
        cyc(1, -(longint'(1) << 37), 1, 0); cyc(0, 0, 1, 0);
        chk("sat_lo", longint'(intf.out_data), -32768);
`ifdef FIRQ_SATCNT_EN
        chk("sat_cnt2", longint'(sat_count), 2);
`endif
        cyc(0, 0, 1, 0);

        // Overfill with consumer stalled, then drain in order
        for (int k = 1; k <= 9; k++) cyc(1, longint'(k) * 32768, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("full_lvl", longint'(intf.fifo_level), 8);
        chk("full_ovf", longint'(intf.overflow), 1);
        for (int k = 1; k <= 8; k++) begin
            chk("drain", longint'(intf.out_data), longint'(k));
            cyc(0, 0, 1, 0);
        end
        chk("drain_vld", longint'(intf.out_valid), 0);

        // Simultaneous push and pop while full
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) cyc(1, longint'(k + 20) * 32768, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 99 * 32768, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pp_lvl", longint'(intf.fifo_level), 8);
        chk("pp_ovf", longint'(intf.overflow), 0);
        chk("pp_head", longint'(intf.out_data), 22);
        cyc(1, 5 * 32768, 0, 0);
        cyc(0, 0, 0, 0);
        chk("drop_ovf", longint'(intf.overflow), 1);
        cyc(0, 0, 0, 1);
        chk("clr_ovf", longint'(intf.overflow), 0);
        cyc(1, 6 * 32768, 0, 0);
        cyc(0, 0, 0, 1);
        chk("set_wins", longint'(intf.overflow), 1);
        repeat (10) cyc(0, 0, 1, 0);

        // Continuous strobes with toggling ready: several pointer laps
        for (int i = 0; i < 60; i++) cyc(1, longint'(i % 500) * 32768, (i % 2) == 0, 0);
        repeat (10) cyc(0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, rnd_in(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        repeat (10) cyc(0, 0, 1, 0);

        // Asynchronous reset mid-burst
        for (int k = 1; k <= 5; k++) cyc(1, longint'(k) * 32768, 0, 0);
        cyc(1, (longint'(1) << 37) - 1, 0, 0);
        chk("pre_rst_lvl", longint'(intf.fifo_level), 5);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", longint'(intf.out_valid), 0);
        chk("arst_dat", longint'(intf.out_data), 0);
        chk("arst_lvl", longint'(intf.fifo_level), 0);
        chk("arst_ovf", longint'(intf.overflow), 0);
`ifdef FIRQ_SATCNT_EN
        chk("arst_satc", longint'(sat_count), 0);
`endif
        model_reset();
        intf.in_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 1, 0);
        cyc(1, 3 * 32768, 1, 0);
        chk("post_rst_n1", longint'(intf.out_valid), 0);
        cyc(0, 0, 1, 0);
        chk("post_rst_n2", longint'(intf.out_valid), 1);
        chk("post_rst_dat", longint'(intf.out_data), 3);
        cyc(0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fir_out_quantizer.md
# fir_out_quantizer

Downstream stage of the FIR filter. Takes the filter's wide signed result (one-cycle `input_valid`-style strobe, no backpressure), rounds and scales it, saturates it to a 16-bit sample, and buffers it in a small FIFO. The FIFO presents the sample on a valid/ready interface to the next consumer (DAC/UART packer). Lost samples and saturation events are flagged so the filter never stalls.

## Interface
- `IN_W`, 38, width of signed FIR result
- `OUT_W`, 16, width of signed output sample
- `SHIFT`, 15, right-shift applied before saturation; legal range 1..IN_W-OUT_W
- `DEPTH`, 8, FIFO entries; power of two, ≥2

One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-low reset
- `in_valid`  in  1  one-cycle strobe from FIR `output_valid`
- `in_data`  in  IN_W  signed FIR `output_data`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  OUT_W  signed FIFO head (show-ahead)
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a sample was dropped
- `ovf_clr`  in  1  synchronous clear of `overflow`
- `sat_count`  out  16  saturation event counter (only with `FIRQ_SATCNT_EN`)

## Operation
- Stage 1 (registered): `r = (in_data + 2^(SHIFT-1)) >>> SHIFT`, computed in IN_W+1 bits signed (no wrap on the add); valid bit `s1_v <= in_valid`.
- Stage 2 (combinational into FIFO write): if `r > 2^(OUT_W-1)-1` → `2^(OUT_W-1)-1`; if `r < -2^(OUT_W-1)` → `-2^(OUT_W-1)`; else `r[OUT_W-1:0]`. Flag `sat` = either clamp taken.
- Rounding is round-half-up (toward +∞ at exact .5): +0.5 → 1, −0.5 → 0, −1.5 → −1.
- FIFO: circular buffer, read/write pointers with wrap, level counter. Push = `s1_v`; pop = `out_valid & out_ready`.
- Push when full without simultaneous pop: sample dropped, `overflow` set, level unchanged.
- Push and pop in the same cycle while full: both occur, level stays DEPTH, no overflow.
- Push and pop in the same cycle while empty: not possible (`out_valid`=0); push only.
- `out_valid` = level≠0. `out_data` reflects the head entry; stable while `out_valid & !out_ready`.
- `ovf_clr` and a new overflow in the same cycle: the set wins (`overflow`=1).
- Reset mid-operation: pipeline valid, pointers, level, flags, and counter are cleared immediately; FIFO contents are discarded. RAM data need not be reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_level`=0, `overflow`=0, `sat_count`=0.
- Latency: `in_valid` sampled at edge N → written at edge N+1 → `out_valid`=1 in the cycle after edge N+1 (2 cycles) if the FIFO was empty.
- Throughput: one sample per cycle sustained when `out_ready`=1.
- `fifo_level` updates on the same edge as the push/pop it reflects.
- Back-to-back `in_valid` on consecutive cycles is legal.

## Configuration
- `FIRQ_SATCNT_EN` defined: `sat_count` port exists. It increments on every pushed-or-dropped stage-2 sample with `sat`=1, saturates at 16'hFFFF (no wrap), and resets to 0.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Defaults. `in_data`=32768 → `out_data`=1, `out_valid` rises 2 cycles after the strobe. `in_data`=16384 → 1. `in_data`=−16384 → 0. `in_data`=−49152 → −1.
- `in_data`=2^37−1 → 32767 and `in_data`=−2^37 → −32768; with `FIRQ_SATCNT_EN`, `sat_count` reads 2.
- Hold `out_ready`=0 and push 9 samples (values 1..9 after scaling) → `fifo_level`=8, `overflow`=1. Drain → outputs 1..8 in order, then `out_valid`=0.
- FIFO full with `out_ready`=1 and a simultaneous push → level stays 8, `overflow` stays 0. Then `ovf_clr` with no push → `overflow`=0.
- Continuous strobes with `out_ready` toggling 1/0 → no loss while level<8, order preserved, pointers wrap correctly over ≥3 laps.
- Assert `rst`=0 mid-burst with level=5 → all outputs at reset values asynchronously. After release, a new sample emerges with 2-cycle latency.
